// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory responder.
package dmem_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  // Request captured at accept and held for the whole transaction
  typedef struct packed {
    op_e               op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/dmem_array.sv
// DEPTH_WORDS x 32 storage: synchronous write, registered read port with clear.
module dmem_array
  import dmem_pkg::*;
#(
  parameter  int unsigned DEPTH_WORDS = 256,
  localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic              rclr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_q;

  // Storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (rclr_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem.sv
// Load/store bus responder with programmable wait states.
// Optional DMEM_ERR_EN rejects misaligned and out-of-range accesses via mem_err.
module data_mem
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr_bus,
  input  logic [DATA_W-1:0] wdata,
  input  logic              mem_read,
  input  logic              mem_wrt,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_ready,
  output logic              mem_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  req_t              req_q, req_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              strobe_c;
  logic              access_c;
  logic              reject_c;
  logic              we_c;
  logic              re_c;
  logic              rclr_c;
  logic [IDX_W-1:0]  idx_c;

  assign strobe_c = mem_wrt | mem_read;
  assign idx_c    = req_q.addr[IDX_W+1:2];

`ifdef DMEM_ERR_EN
  assign reject_c = (req_q.addr[1:0] != 2'b00) ||
                    (req_q.addr[ADDR_W-1:IDX_W+2] != '0);
`else
  logic unused_addr_bits;
  assign reject_c         = 1'b0;
  assign unused_addr_bits = ^{req_q.addr[1:0], req_q.addr[ADDR_W-1:IDX_W+2]};
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (strobe_c)        state_d = ST_BUSY;
      ST_BUSY: if (cnt_q == '0)     state_d = ST_ACK;
      ST_ACK:  if (!strobe_c)       state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    req_d    = req_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    err_d    = err_q;
    access_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (strobe_c) begin
          // Write wins when both strobes are raised together
          req_d.op    = mem_wrt ? OP_WR : OP_RD;
          req_d.addr  = addr_bus;
          req_d.wdata = wdata;
          cnt_d       = CNT_W'(WAIT_CYCLES);
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          access_c = 1'b1;
          ready_d  = 1'b1;
          err_d    = reject_c;
        end
      end
      ST_ACK: begin
        if (!strobe_c) begin
          ready_d = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: begin
        ready_d = 1'b0;
        err_d   = 1'b0;
      end
    endcase
  end

  assign we_c   = access_c && (req_q.op == OP_WR) && !reject_c;
  assign re_c   = access_c && (req_q.op == OP_RD) && !reject_c;
  assign rclr_c = access_c && (req_q.op == OP_RD) &&  reject_c;

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .idx_i   (idx_c),
    .we_i    (we_c),
    .wdata_i (req_q.wdata),
    .re_i    (re_c),
    .rclr_i  (rclr_c),
    .rdata_o (rdata)
  );

  assign mem_ready = ready_q;
  assign mem_err   = err_q;

endmodule

// File: tb/tb_data_mem.sv
// Directed self-checking bench: instance 0 uses WAIT_CYCLES=2, instance 1 uses WAIT_CYCLES=0.
module tb_data_mem;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr_bus  [2];
  logic [31:0] wdata     [2];
  logic        mem_read  [2];
  logic        mem_wrt   [2];
  logic [31:0] rdata     [2];
  logic        mem_ready [2];
  logic        mem_err   [2];

  int checks = 0;
  int errors = 0;

  data_mem #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr_bus  (addr_bus[0]),
    .wdata     (wdata[0]),
    .mem_read  (mem_read[0]),
    .mem_wrt   (mem_wrt[0]),
    .rdata     (rdata[0]),
    .mem_ready (mem_ready[0]),
    .mem_err   (mem_err[0])
  );

  data_mem #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr_bus  (addr_bus[1]),
    .wdata     (wdata[1]),
    .mem_read  (mem_read[1]),
    .mem_wrt   (mem_wrt[1]),
    .rdata     (rdata[1]),
    .mem_ready (mem_ready[1]),
    .mem_err   (mem_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Raise strobes, return cycles from accept edge to first mem_ready (-1 on timeout)
  task automatic issue(input int d, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] w, output int lat);
    @(negedge clk);
    addr_bus[d] = a;
    wdata[d]    = w;
    mem_read[d] = rd;
    mem_wrt[d]  = wr;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_ready[d] === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic release_req(input int d);
    @(negedge clk);
    mem_read[d] = 1'b0;
    mem_wrt[d]  = 1'b0;
    addr_bus[d] = 32'h0000_0ff0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      addr_bus[d] = '0; wdata[d] = '0; mem_read[d] = 1'b0; mem_wrt[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (mem_ready[d] !== 1'b0 || mem_err[d] !== 1'b0 || rdata[d] !== 32'h0) begin
        errors++;
        $display("FAIL reset_values[%0d]: ready=%b err=%b rdata=%h expected 0 0 00000000",
                 d, mem_ready[d], mem_err[d], rdata[d]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_write;
    int lat;
    issue(0, 1'b0, 1'b1, 32'h10, 32'h1111_1111, lat);
    release_req(0);
    @(negedge clk);
    issue(0, 1'b1, 1'b0, 32'h10, 32'h0, lat);
    checks++;
    if (rdata[0] !== 32'h1111_1111) begin
      errors++;
      $display("FAIL preload_read: got %h expected 11111111", rdata[0]);
    end
    release_req(0);
    @(negedge clk);
    // Accept a write, then pull reset while it is still waiting
    @(negedge clk);
    addr_bus[0] = 32'h10; wdata[0] = 32'hDEAD_BEEF; mem_wrt[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    mem_wrt[0] = 1'b0;
    #1;
    checks++;
    if (mem_ready[0] !== 1'b0 || mem_err[0] !== 1'b0 || rdata[0] !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_write: ready=%b err=%b rdata=%h expected 0 0 00000000",
               mem_ready[0], mem_err[0], rdata[0]);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (mem_ready[0] !== 1'b0 || rdata[0] !== 32'h0) begin
      errors++;
      $display("FAIL reset_hold: ready=%b rdata=%h expected 0 00000000", mem_ready[0], rdata[0]);
    end
    rst_n = 1'b1;
    issue(0, 1'b1, 1'b0, 32'h10, 32'h0, lat);
    checks++;
    if (lat != 3 || rdata[0] !== 32'h1111_1111) begin
      errors++;
      $display("FAIL aborted_write_not_committed: lat=%0d rdata=%h expected 3 11111111",
               lat, rdata[0]);
    end
    release_req(0);
    @(negedge clk);
  endtask

  task automatic test_store_load;
    int lat;
    issue(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, lat);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL write_latency: got %0d expected 3", lat);
    end
    checks++;
    if (rdata[0] !== 32'h1111_1111) begin
      errors++;
      $display("FAIL write_keeps_rdata: got %h expected 11111111", rdata[0]);
    end
    release_req(0);
    checks++;
    if (mem_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL write_ready_held: got %b expected 1", mem_ready[0]);
    end
    @(negedge clk);
    checks++;
    if (mem_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL write_ready_drop: got %b expected 0", mem_ready[0]);
    end
    issue(0, 1'b1, 1'b0, 32'h10, 32'h0, lat);
    checks++;
    if (lat != 3 || rdata[0] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL read_back: lat=%0d rdata=%h expected 3 deadbeef", lat, rdata[0]);
    end
    release_req(0);
    checks++;
    if (mem_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL read_ready_held: got %b expected 1", mem_ready[0]);
    end
    @(negedge clk);
    checks++;
    if (mem_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL read_ready_drop: got %b expected 0", mem_ready[0]);
    end
  endtask

  task automatic test_zero_wait;
    int lat;
    issue(1, 1'b0, 1'b1, 32'h24, 32'hCAFE_F00D, lat);
    release_req(1);
    @(negedge clk);
    issue(1, 1'b1, 1'b0, 32'h24, 32'h0, lat);
    checks++;
    if (lat != 1 || rdata[1] !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL zero_wait_read: lat=%0d rdata=%h expected 1 cafef00d", lat, rdata[1]);
    end
    release_req(1);
    @(negedge clk);
    issue(1, 1'b1, 1'b1, 32'h20, 32'h1234_5678, lat);
    checks++;
    if (lat != 1 || rdata[1] !== 32'hCAFE_F00D || mem_err[1] !== 1'b0) begin
      errors++;
      $display("FAIL both_strobes: lat=%0d rdata=%h err=%b expected 1 cafef00d 0",
               lat, rdata[1], mem_err[1]);
    end
    release_req(1);
    @(negedge clk);
    issue(1, 1'b1, 1'b0, 32'h20, 32'h0, lat);
    checks++;
    if (rdata[1] !== 32'h1234_5678) begin
      errors++;
      $display("FAIL both_strobes_committed: got %h expected 12345678", rdata[1]);
    end
    release_req(1);
    @(negedge clk);
  endtask

  task automatic test_wrap;
    int lat;
    logic        exp_err;
    logic [31:0] exp_rd;
`ifdef DMEM_ERR_EN
    exp_err = 1'b1;
    exp_rd  = 32'h0;
`else
    exp_err = 1'b0;
    exp_rd  = 32'hA5A5_0000;
`endif
    issue(0, 1'b0, 1'b1, 32'h0, 32'hA5A5_0000, lat);
    release_req(0);
    @(negedge clk);
    issue(0, 1'b1, 1'b0, 32'h402, 32'h0, lat);
    checks++;
    if (lat != 3 || mem_err[0] !== exp_err || rdata[0] !== exp_rd) begin
      errors++;
      $display("FAIL wrap_read: lat=%0d err=%b rdata=%h expected 3 %b %h",
               lat, mem_err[0], rdata[0], exp_err, exp_rd);
    end
    release_req(0);
    checks++;
    if (mem_err[0] !== exp_err) begin
      errors++;
      $display("FAIL wrap_err_held: got %b expected %b", mem_err[0], exp_err);
    end
    @(negedge clk);
    checks++;
    if (mem_err[0] !== 1'b0 || mem_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL wrap_exit: err=%b ready=%b expected 0 0", mem_err[0], mem_ready[0]);
    end
  endtask

  task automatic test_early_drop;
    int lat;
    @(negedge clk);
    addr_bus[0] = 32'h10; mem_read[0] = 1'b1;
    @(negedge clk);
    mem_read[0] = 1'b0;
    addr_bus[0] = 32'h0;
    lat = -1;
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      if (mem_ready[0] === 1'b1) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat != 3 || rdata[0] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL early_drop_complete: lat=%0d rdata=%h expected 3 deadbeef", lat, rdata[0]);
    end
    @(negedge clk);
    checks++;
    if (mem_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL early_drop_pulse: ready=%b expected 0", mem_ready[0]);
    end
    // New request in the very next cycle
    addr_bus[0] = 32'h0; mem_read[0] = 1'b1;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_ready[0] === 1'b1) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat != 3 || rdata[0] !== 32'hA5A5_0000) begin
      errors++;
      $display("FAIL back_to_back: lat=%0d rdata=%h expected 3 a5a50000", lat, rdata[0]);
    end
    release_req(0);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_reset_mid_write();
    test_store_load();
    test_zero_wait();
    test_wrap();
    test_early_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_mem.md
# data_mem

Word-addressed data memory that serves the CPU's load/store bus: accepts `mem_read`/`mem_wrt` level strobes with a byte address and store data, performs the access after a configurable wait, and returns read data plus a `mem_ready` acknowledge. It sits outside the CPU core on the shared data bus, as the responder for the core's load/store port. Wait states are counted by an internal FSM.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit words; power of two, ≥ 2.
- `WAIT_CYCLES`, 2: extra cycles between accept and access; range 0..15.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `addr_bus`  in  32  byte address from CPU.
- `wdata`  in  32  store data (the CPU's outgoing data bus).
- `mem_read`  in  1  load strobe, level, held until acknowledged.
- `mem_wrt`  in  1  store strobe, level, held until acknowledged.
- `rdata`  out  32  load data (the CPU's incoming data bus).
- `mem_ready`  out  1  access complete; held while strobe held.
- `mem_err`  out  1  access rejected; tied 0 unless `DMEM_ERR_EN`.
- Clocking: one clock; reset is asynchronous and active-low (`clk`, `rst_n`).

## Operation
- FSM states: IDLE, BUSY, ACK.
- IDLE: if `mem_wrt|mem_read`, latch address, `wdata`, op; load `cnt=WAIT_CYCLES`; go BUSY.
- Both strobes high at accept: write wins; read is not performed.
- BUSY: if `cnt!=0`, decrement; if `cnt==0`, perform access, go ACK.
- Access: word index = `addr[log2(DEPTH_WORDS)+1:2]`. Write updates the array; read loads `rdata`.
- ACK: `mem_ready=1`; leave to IDLE on the first edge where both strobes are low.
- Strobe or address changes during BUSY are ignored; latched values are used. A strobe dropped during BUSY still completes the access, with a one-cycle `mem_ready`.
- `rdata` holds its last value until the next completed read. Writes never change it.
- Memory array is not reset; contents are undefined at power-up.

## Timing
- Reset (async assert): state IDLE, `cnt=0`, `rdata=0`, `mem_ready=0`, `mem_err=0`.
- Reset during BUSY aborts the access. A pending write is not committed.
- Accept at edge E0. Access and `mem_ready` rise at edge E0+WAIT_CYCLES+1. Minimum latency is 1 cycle, at `WAIT_CYCLES=0`.
- `rdata` is valid in the same cycle that `mem_ready` first asserts.
- ACK→IDLE and a new accept cannot occur on the same edge. Back-to-back access costs ≥1 idle cycle.
- All outputs are registered; no combinational input-to-output path.

## Configuration
- Macro: `DMEM_ERR_EN`.
- Defined:
  - An access with `addr[1:0]!=0` or `addr >= DEPTH_WORDS*4` is rejected in the access cycle.
  - On reject, the array is untouched and `mem_err=1` together with `mem_ready` throughout ACK.
  - A rejected read sets `rdata=0`.
  - `mem_err` clears on ACK exit.
- Undefined:
  - `addr[1:0]` and the bits above the index are ignored, so addresses wrap modulo the depth.
  - `mem_err` is constant 0.

## Structure
- Package `dmem_pkg`:
  - state enum (IDLE/BUSY/ACK)
  - op encoding (OP_RD/OP_WR)
  - `WORD_BYTES=4`
  - counter width 4
- Sub-module `dmem_array`: `DEPTH_WORDS`×32 storage with synchronous write and a synchronous read port. `data_mem` holds the FSM, latches, and error check.

## Test plan
- Reset mid-write:
  - Write 0xDEADBEEF to 0x10 at `WAIT_CYCLES=2`.
  - Assert `rst_n=0` one cycle after accept.
  - Expect all outputs at reset values.
  - A later read of 0x10 returns the prior contents, not 0xDEADBEEF.
- Basic store/load:
  - Write 0xDEADBEEF to 0x10, then read 0x10.
  - Expect `mem_ready` 3 cycles after each accept and `rdata=0xDEADBEEF`.
  - `mem_ready` stays high until the strobe drops.
- Zero wait, simultaneous strobes:
  - `WAIT_CYCLES=0`; both strobes high with address 0x20 and data 0x12345678.
  - Expect a 1-cycle latency and a committed write.
  - `rdata` keeps its previous value.
- Wrap/error:
  - Read address 0x402 with `DEPTH_WORDS=256`.
  - With `DMEM_ERR_EN`: `mem_err=1` and `rdata=0`.
  - Without it: returns word 0.
- Early strobe drop:
  - Deassert `mem_read` during BUSY.
  - Expect the access to complete, a one-cycle `mem_ready` pulse, and return to IDLE.
  - A new request in the following cycle is accepted.
